// File: rtl/elastic_pipe_reg.sv
// rtl/elastic_pipe_reg.sv - multi-stage valid/ready pipeline register chain with bubble collapse, stall and flush
// Optional macro ELASTIC_PIPE_DATA_CLEAR_EN: data registers reset, flush and drain to zero.
module elastic_pipe_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  input  logic                         stall,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] r;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] d_q   [DEPTH];
  logic [WIDTH-1:0] d_d   [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];

  // Ready ripples back from the output; an empty stage is always ready.
  always_comb begin
    logic carry;
    carry = out_ready;
    r = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      r[i] = !v_q[i] | carry;
      carry = r[i];
    end
  end

  always_comb begin
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v_q[i-1];
      src_d[i] = d_q[i-1];
    end
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
`ifdef ELASTIC_PIPE_DATA_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) d_d[i] = '0;
`endif
    end else if (!stall) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r[i]) begin
          v_d[i] = src_v[i];
          if (src_v[i]) begin
            d_d[i] = src_d[i];
          end
`ifdef ELASTIC_PIPE_DATA_CLEAR_EN
          else if (v_q[i]) begin
            d_d[i] = '0;
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

`ifdef ELASTIC_PIPE_DATA_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) d_q[i] <= d_d[i];
    end
  end
`else
  // Data flops carry no reset; only the valid bits define chain contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) d_q[i] <= d_d[i];
  end
`endif

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(v_q[i]);
  end

  assign in_ready  = r[0] & !stall & !flush;
  assign out_valid = v_q[DEPTH-1] & !stall;
  assign out_data  = d_q[DEPTH-1];

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb/tb_elastic_pipe_reg.sv - scoreboard bench for elastic_pipe_reg with DEPTH=2, WIDTH=32
module tb_elastic_pipe_reg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic [1:0]       occupancy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] sb [$];

  elastic_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .stall     (stall),
    .flush     (flush),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Scoreboard: accepted payloads are queued, delivered payloads must match in order.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_underflow: got out_data=%h, expected no output", out_data);
      end else begin
        logic [WIDTH-1:0] exp_d;
        exp_d = sb.pop_front();
        if (out_data !== exp_d) $display("FAIL sb_data: got %h expected %h", out_data, exp_d);
        else n_pass++;
      end
    end
    if (in_valid && in_ready) sb.push_back(in_data);
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) $display("FAIL %s: got %h expected %h", name, got, exp_v);
    else n_pass++;
  endtask

  task automatic fill2(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = a; next();
    in_data = b; next();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    next(); next();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1)
      $display("FAIL reset: got ov=%b occ=%0d ir=%b expected 0/0/1", out_valid, occupancy, in_ready);
    else n_pass++;
`ifdef ELASTIC_PIPE_DATA_CLEAR_EN
    n_checks++;
    if (out_data !== '0) $display("FAIL reset_data: got %h expected 0", out_data);
    else n_pass++;
`endif
    rst_n = 1'b1;
    next();
  endtask

  task automatic test_stream();
    logic [1:0] peak;
    peak = '0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h11; next();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL stream_lat1: got ov=%b expected 0", out_valid);
    else n_pass++;
    in_data = 32'h22; next();
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL stream_lat2: got ov=%b expected 1", out_valid);
    else n_pass++;
    if (occupancy > peak) peak = occupancy;
    in_data = 32'h33; next();
    if (occupancy > peak) peak = occupancy;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next();
      if (occupancy > peak) peak = occupancy;
    end
    n_checks++;
    if (peak !== 2'd2) $display("FAIL stream_peak: got %0d expected 2", peak);
    else n_pass++;
  endtask

  task automatic test_fill_drain();
    fill2(32'hA, 32'hB);
    in_valid = 1'b1; in_data = 32'hBAD;
    #1;
    n_checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0)
      $display("FAIL full_block: got occ=%0d ir=%b expected 2/0", occupancy, in_ready);
    else n_pass++;
    next();
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("full_out_ready", {31'd0, in_ready}, 32'd1);
    next(); next(); next();
    chk("drain_empty", {30'd0, occupancy}, 32'd0);
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h5; next();
    in_valid = 1'b0; next();
    in_valid = 1'b1; in_data = 32'h6; next();
    in_valid = 1'b0;
    n_checks++;
    if (occupancy !== 2'd2 || out_valid !== 1'b1)
      $display("FAIL bubble: got occ=%0d ov=%b expected 2/1", occupancy, out_valid);
    else n_pass++;
    out_ready = 1'b1;
    next(); next(); next();
  endtask

  task automatic test_stall();
    fill2(32'hA, 32'hB);
    stall = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      next();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || occupancy !== 2'd2)
        $display("FAIL stall_%0d: got ov=%b ir=%b occ=%0d expected 0/0/2", i, out_valid, in_ready, occupancy);
      else n_pass++;
    end
    stall = 1'b0; in_valid = 1'b0;
    next(); next(); next();
    chk("stall_drained", {30'd0, occupancy}, 32'd0);
  endtask

  task automatic test_back_to_back();
    fill2(32'h100, 32'h101);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'h102 + i;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b expected 1", i, in_ready);
      else n_pass++;
      next();
      chk("b2b_occ", {30'd0, occupancy}, 32'd2);
    end
    in_valid = 1'b0;
    next(); next(); next();
  endtask

  task automatic test_flush();
    fill2(32'hC, 32'hD);
    flush = 1'b1; stall = 1'b1; in_valid = 1'b1; in_data = 32'hEE;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    next();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    sb.delete();
    n_checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL flush_empty: got occ=%0d ov=%b expected 0/0", occupancy, out_valid);
    else n_pass++;
`ifdef ELASTIC_PIPE_DATA_CLEAR_EN
    chk("flush_data_zero", out_data, 32'd0);
`endif
    out_ready = 1'b1;
    next(); next();
    chk("flush_no_accept", {31'd0, out_valid}, 32'd0);
    // Flush with an output transfer in the same cycle: head is delivered, rest discarded.
    fill2(32'h1C, 32'h1D);
    flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd1);
    next();
    flush = 1'b0;
    sb.delete();
    chk("flush2_occ", {30'd0, occupancy}, 32'd0);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h61; next();
    in_data = 32'h62; next();
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL async_reset: got ov=%b occ=%0d expected 0/0", out_valid, occupancy);
    else n_pass++;
    in_valid = 1'b0;
    next();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 32'h77; next();
    in_valid = 1'b0;
    chk("rst_lat1", {31'd0, out_valid}, 32'd0);
    next();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h77)
      $display("FAIL rst_lat2: got ov=%b data=%h expected 1/00000077", out_valid, out_data);
    else n_pass++;
    next(); next();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_drain();
    test_bubble();
    test_stall();
    test_back_to_back();
    test_flush();
    test_async_reset();
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
